// File: rtl/trapezoid_event_sequencer_if.sv
// Event readout bus between the trapezoid event sequencer and the readout logic.
// Uses the valid/ready handshake. The event fields are held stable while valid is high and ready is low.
interface trapezoid_event_sequencer_if #(
  parameter int DATA_W = 14,
  parameter int TS_W   = 32
);
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_energy;
  logic [TS_W-1:0]   evt_time;
  logic              evt_pileup;

  modport master (
    output evt_valid,
    output evt_energy,
    output evt_time,
    output evt_pileup,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_energy,
    input  evt_time,
    input  evt_pileup,
    output evt_ready
  );
endinterface

// File: rtl/trapezoid_event_sequencer.sv
// Trapezoid filter sequencer. It controls the filter reset, triggers on threshold crossings,
// samples the flat-top amplitude, enforces dead time, and holds one event for readout.
module trapezoid_event_sequencer #(
  parameter int DATA_W = 14,
  parameter int TS_W   = 32,
  parameter int T_PEAK = 50,
  parameter int T_HOLD = 300,
  parameter int SETTLE = 64,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             threshold,
  input  logic [DATA_W-1:0]             filt_data,
  output logic                          filt_rst,
  trapezoid_event_sequencer_if.master   evt,
  output logic                          busy,
  output logic [CNT_W-1:0]              dropped
);

  localparam int CMAX_A = (T_PEAK > T_HOLD) ? T_PEAK : T_HOLD;
  localparam int CMAX   = (CMAX_A > SETTLE) ? CMAX_A : SETTLE;
  localparam int CW     = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ARMED  = 3'd2,
    S_PEAK   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [TS_W-1:0]   ts_r;
  logic              above_q_r;
  logic [TS_W-1:0]   pend_time_r;
  logic [DATA_W-1:0] pend_energy_r;
  logic              pend_pileup_r;
  logic              filt_rst_r;
  logic              busy_r;
  logic [CNT_W-1:0]  dropped_r;
  logic              evt_valid_r;
  logic [DATA_W-1:0] evt_energy_r;
  logic [TS_W-1:0]   evt_time_r;
  logic              evt_pileup_r;

  logic above_s;
  logic cross_s;
  logic last_settle_s;
  logic last_peak_s;
  logic last_hold_s;
  logic handshake_s;
  logic commit_s;
  logic commit_load_s;

  // Crossing detection, counter terminal counts and commit decision
  always_comb begin
    above_s       = (filt_data > threshold);
    cross_s       = above_s & ~above_q_r;
    last_settle_s = (cnt_r == CW'(SETTLE - 1));
    last_peak_s   = (cnt_r == CW'(T_PEAK - 1));
    last_hold_s   = (cnt_r == CW'(T_HOLD - 1));
    handshake_s   = evt_valid_r & evt.evt_ready;
    // Dropping enable on the last HOLD cycle discards the pending event silently
    commit_s      = (state_r == S_HOLD) & last_hold_s & enable;
    commit_load_s = commit_s & (~evt_valid_r | evt.evt_ready);
  end

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Previous-sample comparator; held high while idle and at the end of settling so a
  // signal already above threshold cannot produce a trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      above_q_r <= 1'b1;
    end else if ((state_r == S_IDLE) || ((state_r == S_SETTLE) && last_settle_s)) begin
      above_q_r <= 1'b1;
    end else begin
      above_q_r <= above_s;
    end
  end

  // Acquisition state machine with registered filter reset and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cnt_r         <= {CW{1'b0}};
      filt_rst_r    <= 1'b1;
      busy_r        <= 1'b0;
      pend_time_r   <= {TS_W{1'b0}};
      pend_energy_r <= {DATA_W{1'b0}};
      pend_pileup_r <= 1'b0;
    end else if ((state_r != S_IDLE) && !enable) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CW{1'b0}};
      filt_rst_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          filt_rst_r <= !enable;
          busy_r     <= 1'b0;
          cnt_r      <= {CW{1'b0}};
          if (enable) begin
            state_r <= S_SETTLE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (last_settle_s) begin
            state_r <= S_ARMED;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_ARMED: begin
          cnt_r <= {CW{1'b0}};
          if (cross_s) begin
            state_r       <= S_PEAK;
            pend_time_r   <= ts_r;
            pend_pileup_r <= 1'b0;
            busy_r        <= 1'b1;
          end else begin
            state_r <= S_ARMED;
          end
        end
        S_PEAK: begin
          if (cross_s) begin
            pend_pileup_r <= 1'b1;
          end else begin
            pend_pileup_r <= pend_pileup_r;
          end
          if (last_peak_s) begin
            state_r       <= S_HOLD;
            pend_energy_r <= filt_data;
            cnt_r         <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_HOLD: begin
          if (cross_s) begin
            pend_pileup_r <= 1'b1;
          end else begin
            pend_pileup_r <= pend_pileup_r;
          end
          if (last_hold_s) begin
            state_r <= S_ARMED;
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          cnt_r      <= {CW{1'b0}};
          filt_rst_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Output event register, handshake and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_r  <= 1'b0;
      evt_energy_r <= {DATA_W{1'b0}};
      evt_time_r   <= {TS_W{1'b0}};
      evt_pileup_r <= 1'b0;
      dropped_r    <= {CNT_W{1'b0}};
    end else if (commit_load_s) begin
      evt_valid_r  <= 1'b1;
      evt_energy_r <= pend_energy_r;
      evt_time_r   <= pend_time_r;
      // A crossing on the very last HOLD cycle still counts as pile-up
      evt_pileup_r <= pend_pileup_r | cross_s;
    end else begin
      if (handshake_s) begin
        evt_valid_r <= 1'b0;
      end else begin
        evt_valid_r <= evt_valid_r;
      end
      if (commit_s && (dropped_r != {CNT_W{1'b1}})) begin
        dropped_r <= dropped_r + CNT_W'(1);
      end else begin
        dropped_r <= dropped_r;
      end
    end
  end

  assign filt_rst       = filt_rst_r;
  assign busy           = busy_r;
  assign dropped        = dropped_r;
  assign evt.evt_valid  = evt_valid_r;
  assign evt.evt_energy = evt_energy_r;
  assign evt.evt_time   = evt_time_r;
  assign evt.evt_pileup = evt_pileup_r;

endmodule

// File: tb/tb_trapezoid_event_sequencer.sv
// Directed bench for trapezoid_event_sequencer using default timing (T_PEAK=50, T_HOLD=300, SETTLE=64).
// Inputs change and outputs are sampled on the falling edge.
module tb_trapezoid_event_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [13:0] threshold;
  logic [13:0] filt_data;
  logic        filt_rst;
  logic        busy;
  logic [15:0] dropped;
  logic [31:0] bcyc;

  int n_tests;
  int n_fail;

  trapezoid_event_sequencer_if #(.DATA_W(14), .TS_W(32)) evt_bus ();

  trapezoid_event_sequencer #(
    .DATA_W(14), .TS_W(32), .T_PEAK(50), .T_HOLD(300), .SETTLE(64), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .threshold (threshold),
    .filt_data (filt_data),
    .filt_rst  (filt_rst),
    .evt       (evt_bus),
    .busy      (busy),
    .dropped   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: zero in the first cycle after reset
  always @(posedge clk) begin
    if (rst) bcyc <= 32'd0;
    else     bcyc <= bcyc + 32'd1;
  end

  typedef struct {
    logic [13:0] rise;
    logic [13:0] peak;
    bit          pile;
    bit          ready;
    bit          ack;
    logic [13:0] exp_energy;
    bit          exp_pileup;
    int          time_src;
    logic [15:0] exp_dropped;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] trig_time[6];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Trigger at cycle t; the peak value is present at t+50; optional re-crossing in HOLD
  task automatic run_pulse(input int i);
    vec_t v;
    v = vecs[i];
    filt_data = v.rise;
    trig_time[i] = bcyc;
    step(1);
    check($sformatf("v%0d busy_t+1", i), busy, 1);
    step(49);
    filt_data = v.peak;
    step(1);
    filt_data = v.rise;
    if (v.pile) begin
      step(49);
      filt_data = 14'd0;
      step(1);
      filt_data = 14'd800;
      step(249);
    end else begin
      step(299);
    end
    check($sformatf("v%0d busy_last_hold", i), busy, 1);
    evt_ready_drive(v.ready);
    step(1);
    evt_ready_drive(1'b0);
    check($sformatf("v%0d busy_done", i), busy, 0);
    check($sformatf("v%0d valid", i), evt_bus.evt_valid, 1);
    check($sformatf("v%0d energy", i), evt_bus.evt_energy, v.exp_energy);
    check($sformatf("v%0d time", i), evt_bus.evt_time, trig_time[v.time_src]);
    check($sformatf("v%0d pileup", i), evt_bus.evt_pileup, v.exp_pileup);
    check($sformatf("v%0d dropped", i), dropped, v.exp_dropped);
    step(1);
    check($sformatf("v%0d no_retrigger", i), busy, 0);
    filt_data = 14'd0;
    if (v.ack) begin
      evt_ready_drive(1'b1);
      step(1);
      evt_ready_drive(1'b0);
      check($sformatf("v%0d ack_clears", i), evt_bus.evt_valid, 0);
    end
    step(1);
  endtask

  task automatic evt_ready_drive(input logic r);
    evt_bus.evt_ready = r;
  endtask

  initial begin
    logic [31:0] t0;
    n_tests = 0;
    n_fail  = 0;
    //          rise     peak     pile  rdy   ack   energy    pu    src dropped
    vecs[0] = '{14'd1000, 14'd2000, 1'b0, 1'b0, 1'b0, 14'd2000, 1'b0, 0, 16'd0};
    vecs[1] = '{14'd1000, 14'd1500, 1'b1, 1'b1, 1'b1, 14'd1500, 1'b1, 1, 16'd0};
    vecs[2] = '{14'd1000, 14'd3000, 1'b0, 1'b0, 1'b0, 14'd3000, 1'b0, 2, 16'd0};
    vecs[3] = '{14'd1000, 14'd3100, 1'b0, 1'b0, 1'b0, 14'd3000, 1'b0, 2, 16'd1};
    vecs[4] = '{14'd1000, 14'd3200, 1'b0, 1'b0, 1'b0, 14'd3000, 1'b0, 2, 16'd2};
    vecs[5] = '{14'd1200, 14'd3300, 1'b0, 1'b1, 1'b0, 14'd3300, 1'b0, 5, 16'd2};

    rst = 1'b1;
    enable = 1'b0;
    threshold = 14'd100;
    filt_data = 14'd0;
    evt_bus.evt_ready = 1'b0;
    step(3);
    check("rst filt_rst", filt_rst, 1);
    check("rst valid", evt_bus.evt_valid, 0);
    check("rst energy", evt_bus.evt_energy, 0);
    check("rst time", evt_bus.evt_time, 0);
    check("rst pileup", evt_bus.evt_pileup, 0);
    check("rst busy", busy, 0);
    check("rst dropped", dropped, 0);
    rst = 1'b0;
    step(2);
    check("idle filt_rst", filt_rst, 1);

    // Enable; a rise during settling and a level held above threshold must not trigger
    enable = 1'b1;
    step(1);
    check("enable filt_rst_low", filt_rst, 0);
    step(10);
    filt_data = 14'd500;
    step(54);
    check("settle no_busy", busy, 0);
    step(20);
    check("armed_high no_busy", busy, 0);
    check("armed_high no_valid", evt_bus.evt_valid, 0);

    // Re-enable with the level already above threshold
    enable = 1'b0;
    step(1);
    check("disable filt_rst", filt_rst, 1);
    step(3);
    enable = 1'b1;
    step(1);
    check("reenable filt_rst_low", filt_rst, 0);
    step(74);
    check("pre_high no_busy", busy, 0);
    filt_data = 14'd100;
    step(2);
    check("equal_thr no_busy", busy, 0);
    filt_data = 14'd101;
    t0 = bcyc;
    step(1);
    check("thr+1 busy", busy, 1);
    step(349);
    check("thr+1 valid_late", evt_bus.evt_valid, 0);
    step(1);
    check("thr+1 valid", evt_bus.evt_valid, 1);
    check("thr+1 energy", evt_bus.evt_energy, 101);
    check("thr+1 time", evt_bus.evt_time, t0);
    check("thr+1 pileup", evt_bus.evt_pileup, 0);
    filt_data = 14'd0;
    evt_bus.evt_ready = 1'b1;
    step(1);
    evt_bus.evt_ready = 1'b0;
    check("thr+1 ack", evt_bus.evt_valid, 0);
    step(1);

    for (int i = 0; i < 6; i++) begin
      run_pulse(i);
    end

    // Enable drops mid-PEAK while an event is still held in the output register
    filt_data = 14'd1000;
    step(20);
    enable = 1'b0;
    step(1);
    check("abort filt_rst", filt_rst, 1);
    check("abort busy", busy, 0);
    step(340);
    check("abort valid_kept", evt_bus.evt_valid, 1);
    check("abort energy_kept", evt_bus.evt_energy, 3300);
    check("abort time_kept", evt_bus.evt_time, trig_time[5]);
    check("abort dropped", dropped, 2);
    evt_bus.evt_ready = 1'b1;
    step(1);
    evt_bus.evt_ready = 1'b0;
    check("abort ack", evt_bus.evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trapezoid_event_sequencer.md
# trapezoid_event_sequencer

Sequencer and event builder for the scintillator trapezoid filter. It controls the filter's reset, detects threshold crossings on the filtered stream, and samples the flat-top amplitude a fixed delay after each trigger. It also enforces dead time, flags pile-up, and presents one timestamped event at a time on a valid/ready interface to the readout logic.

## Interface
- DATA_W, 14, width of filtered samples and threshold (unsigned)
- TS_W, 32, timestamp width
- T_PEAK, 50, cycles from trigger to amplitude sample (>=1)
- T_HOLD, 300, dead-time cycles after the amplitude sample (>=1)
- SETTLE, 64, cycles after enable during which triggers are ignored (>=1)
- CNT_W, 16, dropped-event counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  acquisition enable, level
- threshold  in  DATA_W  trigger level, held static while enable=1
- filt_data  in  DATA_W  filter output, one sample per cycle
- filt_rst  out  1  reset to the trapezoid filter
- evt_valid  out  1  event register holds an unread event
- evt_ready  in  1  consumer accepts the event when evt_valid&evt_ready
- evt_energy  out  DATA_W  sampled amplitude
- evt_time  out  TS_W  timestamp of the trigger cycle
- evt_pileup  out  1  second crossing seen during PEAK/HOLD
- busy  out  1  state is PEAK or HOLD
- dropped  out  CNT_W  events lost because the event register was full (saturating)

## Operation
- Free-running timestamp `ts` increments every cycle and wraps modulo 2^TS_W. It is 0 in the first cycle after reset.
- Edge detector: `above = filt_data > threshold` (strictly greater), with registered `above_q`. `cross = above & ~above_q`. `above_q` updates every cycle in all states except IDLE, where it is held at 1.
- States:
  - IDLE: filt_rst=1. On enable=1 go to SETTLE.
  - SETTLE: filt_rst=0. Counts SETTLE cycles, then goes to ARMED. `cross` is ignored. `above_q` is forced to 1 on the last SETTLE cycle, so a signal already above threshold does not trigger.
  - ARMED: on `cross`, latch `ts` into the pending time, clear pending pileup, and go to PEAK.
  - PEAK: counts T_PEAK cycles. On the T_PEAK-th cycle after the trigger, latch filt_data into pending energy and go to HOLD. Any `cross` while in PEAK sets pending pileup.
  - HOLD: counts T_HOLD cycles. `cross` sets pending pileup. When the count ends, commit the event (below) and go to ARMED.
- Commit: if evt_valid=0, or evt_ready=1 in the same cycle, load the event register and set evt_valid=1. Otherwise discard the pending event and increment `dropped`, saturating at all-ones.
- evt_valid clears on handshake, unless a commit loads a new event in the same cycle.
- enable=0 in any non-IDLE state: on the next edge go to IDLE with filt_rst=1. Any pending event is discarded without counting a drop. The event register and evt_valid are not affected.
- Re-arming needs a fresh crossing. A signal still above threshold at the end of HOLD does not retrigger.

## Timing
- Reset values: filt_rst=1, evt_valid=0, evt_energy=0, evt_time=0, evt_pileup=0, busy=0, dropped=0, state=IDLE, ts=0.
- Enable is sampled at edge e, so filt_rst=0 from cycle e+1. ARMED is entered at e+1+SETTLE.
- Trigger at cycle t (`cross`=1 in ARMED):
  - evt_time = ts(t).
  - evt_energy = filt_data(t+T_PEAK).
  - busy=1 from t+1 through t+T_PEAK+T_HOLD.
  - evt_valid=1 from t+T_PEAK+T_HOLD+1.
  - A new trigger is possible from t+T_PEAK+T_HOLD+1.
- The event output is registered. evt_energy, evt_time and evt_pileup are stable while evt_valid=1 and evt_ready=0.
- rst has priority over every other input.

## Test plan
- Reset, then enable=1 with threshold=100 and filt_data=0 -> filt_rst falls one cycle after enable. No event for SETTLE cycles.
- Hold filt_data=500 before enable and through SETTLE, threshold=100 -> no trigger until filt_data drops to ≤100 and rises again.
- In ARMED, step filt_data 0->1000 at cycle t, with value 2000 at t+50 (defaults) -> evt_valid rises at t+351 with evt_energy=2000, evt_time=ts(t), evt_pileup=0.
- During HOLD, drop filt_data to 0, then raise to 800 -> event reported with evt_pileup=1. No second event from that crossing.
- evt_ready=0, three triggered pulses -> first event retained unchanged, dropped=2. Then evt_ready=1 coincident with a commit -> new event loaded, dropped unchanged.
- Deassert enable mid-PEAK -> filt_rst=1 next cycle, no event, dropped unchanged. A previously valid event is still readable.
